// File: rtl/stream_crossbar_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stream_crossbar_rr                                           |
// | Description : Packet-aware stream crossbar with per-sink round-robin       |
// |               arbitration, packet locking and registered outputs.          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stream_crossbar_rr #(
    parameter int T_DATA_WIDTH = 8,
    parameter int S_DATA_COUNT = 5,
    parameter int M_DATA_COUNT = 3,
    parameter int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    parameter int T_DEST_WIDTH = $clog2(M_DATA_COUNT)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [T_DATA_WIDTH*S_DATA_COUNT-1:0] s_data_i,
    input  logic [S_DATA_COUNT-1:0]              s_valid_i,
    input  logic [S_DATA_COUNT-1:0]              s_last_i,
    input  logic [T_DEST_WIDTH*S_DATA_COUNT-1:0] s_dest_i,
    output logic [S_DATA_COUNT-1:0]              s_ready_o,
    output logic [T_DATA_WIDTH*M_DATA_COUNT-1:0] m_data_o,
    output logic [M_DATA_COUNT-1:0]              m_valid_o,
    output logic [M_DATA_COUNT-1:0]              m_last_o,
    output logic [T_ID___WIDTH*M_DATA_COUNT-1:0] m_id_o,
    input  logic [M_DATA_COUNT-1:0]              m_ready_i,
    output logic [S_DATA_COUNT*M_DATA_COUNT-1:0] grant_o,
    output logic [S_DATA_COUNT-1:0]              err_o
);
    localparam int TW = T_DATA_WIDTH;
    localparam int S  = S_DATA_COUNT;
    localparam int M  = M_DATA_COUNT;
    localparam int IW = T_ID___WIDTH;
    localparam int DW = T_DEST_WIDTH;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_q  [M];
    state_t          state_d  [M];
    logic [IW-1:0]   src_q    [M];
    logic [IW-1:0]   src_d    [M];
    logic [IW-1:0]   ptr_q    [M];
    logic [IW-1:0]   ptr_d    [M];
    logic [IW-1:0]   m_id_q   [M];
    logic [IW-1:0]   m_id_d   [M];
    logic [TW-1:0]   m_data_q [M];
    logic [TW-1:0]   m_data_d [M];
    logic [M-1:0]    m_valid_q, m_valid_d;
    logic [M-1:0]    m_last_q,  m_last_d;
    logic [M-1:0]    accept;
    logic [S-1:0]    src_locked;
    logic [S-1:0]    bad_dest;
    logic [S-1:0]    req      [M];

    // Source side: lock status, requests, bad-destination drop and ready.
    always_comb begin
        src_locked = '0;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < S; j++) begin
                if (state_q[i] == ST_LOCKED && src_q[i] == IW'(j))
                    src_locked[j] = 1'b1;
            end
        end
        for (int j = 0; j < S; j++) begin
            bad_dest[j] = s_valid_i[j] && !src_locked[j] &&
                          (int'(s_dest_i[j*DW +: DW]) >= M);
        end
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < S; j++) begin
                req[i][j] = s_valid_i[j] && !src_locked[j] &&
                            (s_dest_i[j*DW +: DW] == DW'(i));
            end
        end
        s_ready_o = bad_dest;
        for (int i = 0; i < M; i++) begin
            if (state_q[i] == ST_LOCKED)
                s_ready_o[src_q[i]] = s_ready_o[src_q[i]] | !m_valid_q[i] | m_ready_i[i];
        end
        if (!rst)
            s_ready_o = '0;
        err_o = rst ? bad_dest : '0;
    end

    // Per-sink arbiter FSM and output register next state.
    always_comb begin
        logic found;
        int   idx;
        found     = 1'b0;
        idx       = 0;
        accept    = '0;
        m_valid_d = m_valid_q;
        m_last_d  = m_last_q;
        for (int i = 0; i < M; i++) begin
            state_d[i]  = state_q[i];
            src_d[i]    = src_q[i];
            ptr_d[i]    = ptr_q[i];
            m_data_d[i] = m_data_q[i];
            m_id_d[i]   = m_id_q[i];
            found       = 1'b0;
            accept[i]   = (state_q[i] == ST_LOCKED) && s_valid_i[src_q[i]] &&
                          (!m_valid_q[i] || m_ready_i[i]);
            case (state_q[i])
                ST_IDLE: begin
                    for (int k = 0; k < S; k++) begin
                        idx = (int'(ptr_q[i]) + k) % S;
                        if (!found && req[i][idx]) begin
                            found    = 1'b1;
                            src_d[i] = IW'(idx);
                        end
                    end
                    if (found)
                        state_d[i] = ST_LOCKED;
                end
                ST_LOCKED: begin
                    if (accept[i] && s_last_i[src_q[i]]) begin
                        state_d[i] = ST_IDLE;
                        ptr_d[i]   = (int'(src_q[i]) == S - 1) ? '0 : src_q[i] + 1'b1;
                    end
                end
                default: state_d[i] = ST_IDLE;
            endcase
            if (accept[i]) begin
                m_valid_d[i] = 1'b1;
                m_last_d[i]  = s_last_i[src_q[i]];
                m_data_d[i]  = s_data_i[int'(src_q[i])*TW +: TW];
                m_id_d[i]    = src_q[i];
            end else if (m_ready_i[i]) begin
                m_valid_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            m_valid_q <= '0;
            m_last_q  <= '0;
            for (int i = 0; i < M; i++) begin
                state_q[i]  <= ST_IDLE;
                src_q[i]    <= '0;
                ptr_q[i]    <= '0;
                m_data_q[i] <= '0;
                m_id_q[i]   <= '0;
            end
        end else begin
            m_valid_q <= m_valid_d;
            m_last_q  <= m_last_d;
            for (int i = 0; i < M; i++) begin
                state_q[i]  <= state_d[i];
                src_q[i]    <= src_d[i];
                ptr_q[i]    <= ptr_d[i];
                m_data_q[i] <= m_data_d[i];
                m_id_q[i]   <= m_id_d[i];
            end
        end
    end

    assign m_valid_o = m_valid_q;
    assign m_last_o  = m_last_q;

    generate
        for (genvar i = 0; i < M; i++) begin : g_sink
            assign m_data_o[i*TW +: TW] = m_data_q[i];
            assign m_id_o[i*IW +: IW]   = m_id_q[i];
            for (genvar j = 0; j < S; j++) begin : g_src
                assign grant_o[i*S + j] = (state_q[i] == ST_LOCKED) && (src_q[i] == IW'(j));
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_stream_crossbar_rr.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stream_crossbar_rr                                        |
// | Description : Scoreboard bench for stream_crossbar_rr, directed packets.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stream_crossbar_rr;
    localparam int TW = 8;
    localparam int S  = 5;
    localparam int M  = 3;
    localparam int IW = 3;
    localparam int DW = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [TW*S-1:0]   s_data_i;
    logic [S-1:0]      s_valid_i, s_last_i, s_ready_o, err_o;
    logic [DW*S-1:0]   s_dest_i;
    logic [TW*M-1:0]   m_data_o;
    logic [M-1:0]      m_valid_o, m_last_o, m_ready_i;
    logic [IW*M-1:0]   m_id_o;
    logic [S*M-1:0]    grant_o;

    logic              sv   [S];
    logic [TW-1:0]     sd   [S];
    logic              sl   [S];
    logic [DW-1:0]     sdst [S];

    typedef struct packed {
        logic [IW-1:0] id;
        logic          last;
        logic [TW-1:0] data;
    } beat_t;

    beat_t expq [M][$];
    time   t0 [$];
    time   t2 [$];
    int    total = 0;
    int    bad   = 0;
    bit    bp_chk = 1'b0;

    stream_crossbar_rr dut (
        .clk(clk), .rst(rst),
        .s_data_i(s_data_i), .s_valid_i(s_valid_i), .s_last_i(s_last_i),
        .s_dest_i(s_dest_i), .s_ready_o(s_ready_o),
        .m_data_o(m_data_o), .m_valid_o(m_valid_o), .m_last_o(m_last_o),
        .m_id_o(m_id_o), .m_ready_i(m_ready_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int j = 0; j < S; j++) begin
            s_valid_i[j]          = sv[j];
            s_last_i[j]           = sl[j];
            s_data_i[j*TW +: TW]  = sd[j];
            s_dest_i[j*DW +: DW]  = sdst[j];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic beat_t mk(input int id, input bit last, input logic [TW-1:0] d);
        return {IW'(id), last, d};
    endfunction

    task automatic monitor();
        beat_t got;
        beat_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                for (int i = 0; i < M; i++) begin
                    if (m_valid_o[i] && m_ready_i[i]) begin
                        got = {m_id_o[i*IW +: IW], m_last_o[i], m_data_o[i*TW +: TW]};
                        if (i == 0) t0.push_back($time);
                        if (i == 2) t2.push_back($time);
                        if (expq[i].size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL m%0d unexpected beat: got %0h expected none", i, got);
                        end else begin
                            e = expq[i].pop_front();
                            check($sformatf("m%0d beat", i), 64'(got), 64'(e));
                        end
                    end
                end
                if (bp_chk && m_valid_o[2] && !m_ready_i[2])
                    check("bp s_ready3", 64'(s_ready_o[3]), 64'd0);
            end
        end
    endtask

    // Drives n beats from source j: first beat to dst0, the rest to dst1.
    task automatic send(input int j, input int n, input logic [TW-1:0] base,
                        input int dst0, input int dst1);
        int t;
        for (int b = 0; b < n; b++) begin
            sv[j]   = 1'b1;
            sd[j]   = base + TW'(b);
            sl[j]   = (b == n - 1);
            sdst[j] = DW'((b == 0) ? dst0 : dst1);
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!s_ready_o[j] && t < 200);
            if (!s_ready_o[j]) begin
                check($sformatf("src%0d ready timeout", j), 64'd0, 64'd1);
                sv[j] = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        sv[j] = 1'b0;
        sl[j] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int t;
        for (int j = 0; j < S; j++) begin
            sv[j] = 1'b0; sd[j] = '0; sl[j] = 1'b0; sdst[j] = '0;
        end
        m_ready_i = '1;
        rst       = 1'b0;
        sv[0]     = 1'b1;
        fork monitor(); join_none

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst m_valid", 64'(m_valid_o), 64'd0);
        check("rst grant",   64'(grant_o),   64'd0);
        check("rst err",     64'(err_o),     64'd0);
        check("rst s_ready", 64'(s_ready_o), 64'd0);
        check("rst m_data",  64'(m_data_o),  64'd0);
        @(posedge clk); #1;
        rst   = 1'b1;
        sv[0] = 1'b0;
        idle(2);

        // Single route with grant visibility
        expq[1].push_back(mk(2, 0, 8'hA1));
        expq[1].push_back(mk(2, 0, 8'hA2));
        expq[1].push_back(mk(2, 1, 8'hA3));
        fork
            send(2, 3, 8'hA1, 1, 1);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (!m_valid_o[1] && t < 20);
                check("t1 grant", 64'(grant_o), 64'h80);
            end
        join
        idle(4);

        // Round-robin fairness on sink 0
        t0.delete();
        expq[0].push_back(mk(0, 1, 8'h00));
        expq[0].push_back(mk(1, 1, 8'h10));
        expq[0].push_back(mk(4, 1, 8'h40));
        expq[0].push_back(mk(0, 1, 8'h01));
        expq[0].push_back(mk(1, 1, 8'h11));
        expq[0].push_back(mk(4, 1, 8'h41));
        fork
            begin send(0, 1, 8'h00, 0, 0); send(0, 1, 8'h01, 0, 0); end
            begin send(1, 1, 8'h10, 0, 0); send(1, 1, 8'h11, 0, 0); end
            begin send(4, 1, 8'h40, 0, 0); send(4, 1, 8'h41, 0, 0); end
        join
        idle(4);
        check("t2 span", (t0.size() == 6) ? 64'(t0[5] - t0[0]) : 64'd0, 64'd100);

        // Backpressure on sink 2
        bp_chk = 1'b1;
        for (int b = 0; b < 4; b++)
            expq[2].push_back(mk(3, b == 3, 8'h30 + 8'(b)));
        fork
            send(3, 4, 8'h30, 2, 2);
            begin
                idle(2);
                m_ready_i[2] = 1'b0;
                idle(3);
                m_ready_i[2] = 1'b1;
            end
        join
        idle(4);
        bp_chk = 1'b0;

        // Parallel sinks at full rate
        t0.delete();
        t2.delete();
        for (int b = 0; b < 4; b++) begin
            expq[0].push_back(mk(0, b == 3, 8'h50 + 8'(b)));
            expq[2].push_back(mk(1, b == 3, 8'h60 + 8'(b)));
        end
        fork
            send(0, 4, 8'h50, 0, 0);
            send(1, 4, 8'h60, 2, 2);
        join
        idle(4);
        check("t4 m0 span", (t0.size() == 4) ? 64'(t0[3] - t0[0]) : 64'd0, 64'd30);
        check("t4 m2 span", (t2.size() == 4) ? 64'(t2[3] - t2[0]) : 64'd0, 64'd30);

        // Route held when dest changes mid-packet
        t2.delete();
        expq[0].push_back(mk(0, 0, 8'h70));
        expq[0].push_back(mk(0, 0, 8'h71));
        expq[0].push_back(mk(0, 1, 8'h72));
        send(0, 3, 8'h70, 0, 2);
        idle(4);
        check("t4 m2 quiet", 64'(t2.size()), 64'd0);

        // Bad destination
        sv[4] = 1'b1; sdst[4] = 2'd3; sd[4] = 8'hEE; sl[4] = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("bad s_ready4", 64'(s_ready_o[4]), 64'd1);
            check("bad err",      64'(err_o),        64'h10);
            check("bad m_valid",  64'(m_valid_o),    64'd0);
        end
        @(posedge clk); #1;
        sv[4] = 1'b0; sl[4] = 1'b0;
        @(negedge clk);
        check("bad err clear", 64'(err_o), 64'd0);
        idle(2);

        // Reset mid-packet, then arbitration restarts from pointer 0
        m_ready_i[1] = 1'b0;
        sv[2] = 1'b1; sd[2] = 8'h80; sl[2] = 1'b0; sdst[2] = 2'd1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_ready_o[2] && t < 20);
        check("t6 ready", 64'(s_ready_o[2]), 64'd1);
        @(posedge clk); #1;
        sd[2] = 8'h81;
        rst   = 1'b0;
        @(negedge clk);
        check("t6 s_ready in rst", 64'(s_ready_o), 64'd0);
        @(posedge clk); #1;
        rst          = 1'b1;
        sv[2]        = 1'b0;
        m_ready_i[1] = 1'b1;
        @(negedge clk);
        check("t6 m_valid", 64'(m_valid_o), 64'd0);
        check("t6 grant",   64'(grant_o),   64'd0);
        @(posedge clk); #1;
        expq[1].push_back(mk(0, 1, 8'h90));
        expq[1].push_back(mk(3, 1, 8'h93));
        fork
            send(3, 1, 8'h93, 1, 1);
            send(0, 1, 8'h90, 1, 1);
        join
        idle(5);

        for (int i = 0; i < M; i++)
            check($sformatf("m%0d leftover", i), 64'(expq[i].size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
